// File: rtl/can_timing_pkg.sv
// rtl/can_timing_pkg.sv - shared CAN bit timing encodings, sync FSM states and SJW helper
package can_timing_pkg;

  localparam logic [1:0] SYNC_SEG   = 2'b00;
  localparam logic [1:0] PROP_SEG   = 2'b01;
  localparam logic [1:0] PHASE_SEG1 = 2'b10;
  localparam logic [1:0] PHASE_SEG2 = 2'b11;

  localparam logic [3:0] SJW_MAX = 4'd4;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'b00,
    ST_TRACK   = 2'b01,
    ST_PENDING = 2'b10,
    ST_ACTIVE  = 2'b11
  } sync_state_e;

  // A programmed SJW of 0 still allows one quantum of correction.
  function automatic logic [3:0] clamp_sjw(input logic [3:0] sjw);
    if (sjw == 4'd0) begin
      return 4'd1;
    end else if (sjw > SJW_MAX) begin
      return SJW_MAX;
    end else begin
      return sjw;
    end
  endfunction

endpackage

// File: rtl/can_rx_synchronizer.sv
// rtl/can_rx_synchronizer.sv - metastability flop chain for the raw CAN rx pin
module can_rx_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rx_i,
  output logic rx_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the pin through the chain; reset to recessive so no false edge appears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/can_sync_controller.sv
// rtl/can_sync_controller.sv - CAN hard sync / SJW-limited resynchronization controller
module can_sync_controller
  import can_timing_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       tq_pulse,
  input  logic       rx,
  input  logic       hard_sync_enable,
  input  logic [3:0] sjw,
  input  logic [3:0] phase_seg1,
  input  logic [3:0] phase_seg2,
  input  logic [1:0] current_segment,
  input  logic [4:0] quanta_counter,
  input  logic [4:0] bit_quanta_counter,
  input  logic       sample_point,
  input  logic       bit_timing_end,
  output logic       apply_hard_sync,
  output logic       apply_resync,
  output logic [3:0] sync_adjustment,
  output logic       sync_direction,
  output logic       sampled_bit,
  output logic       edge_pulse,
  output logic       sync_ignored
);

  logic              rx_s;
  logic              rx_prev_q;
  logic              edge_pulse_q;
  logic              sampled_bit_q;
  sync_state_e       state_q;
  logic              sync_lock_q;
  logic              hse_q;
  logic [3:0]        adj_q;
  logic              dir_q;
  logic              apply_hard_sync_q;
  logic              apply_resync_q;
  logic [3:0]        sync_adjustment_q;
  logic              sync_direction_q;
  logic              sync_ignored_q;

  logic              edge_det;
  logic [3:0]        sjw_eff;
  logic signed [5:0] lim;
  logic [4:0]        ph1_last;
  logic [3:0]        adj_fwd;
  logic [3:0]        adj_bwd;

  can_rx_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  // Edge detection at tq granularity plus phase-error magnitudes for both directions.
  always_comb begin
    edge_det = tq_pulse && rx_prev_q && !rx_s;
    sjw_eff  = clamp_sjw(sjw);
    ph1_last = {1'b0, phase_seg1} - 5'd1;
    lim      = $signed({2'b00, phase_seg2}) - $signed({1'b0, quanta_counter}) - 6'sd2;
    adj_fwd  = bit_quanta_counter[3:0];
    if ({1'b0, sjw_eff} < bit_quanta_counter) begin
      adj_fwd = sjw_eff;
    end
    adj_bwd = lim[3:0];
    if (lim > $signed({2'b00, sjw_eff})) begin
      adj_bwd = sjw_eff;
    end
  end

  // Previous tq rx value, registered edge flag and the sample-point capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev_q     <= 1'b1;
      edge_pulse_q  <= 1'b0;
      sampled_bit_q <= 1'b1;
    end else begin
      if (tq_pulse) begin
        rx_prev_q <= rx_s;
      end
      edge_pulse_q <= enable && edge_det;
      if (sample_point) begin
        sampled_bit_q <= rx_s;
      end
    end
  end

  // Sync FSM: hard sync beats resync; resync waits for PHASE1 and holds until end of bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_ARMED;
      sync_lock_q       <= 1'b0;
      hse_q             <= 1'b0;
      adj_q             <= 4'd0;
      dir_q             <= 1'b0;
      apply_hard_sync_q <= 1'b0;
      apply_resync_q    <= 1'b0;
      sync_adjustment_q <= 4'd0;
      sync_direction_q  <= 1'b0;
      sync_ignored_q    <= 1'b0;
    end else begin
      hse_q             <= hard_sync_enable;
      apply_hard_sync_q <= 1'b0;
      sync_ignored_q    <= 1'b0;
      if (!enable) begin
        state_q           <= hard_sync_enable ? ST_ARMED : ST_TRACK;
        sync_lock_q       <= 1'b0;
        apply_resync_q    <= 1'b0;
        sync_adjustment_q <= 4'd0;
        sync_direction_q  <= 1'b0;
      end else begin
        if (bit_timing_end) begin
          sync_lock_q <= 1'b0;
        end
        if (edge_det && hard_sync_enable) begin
          // Hard sync from any state, aborting a pending or active resync.
          apply_hard_sync_q <= 1'b1;
          sync_lock_q       <= 1'b1;
          state_q           <= ST_TRACK;
          apply_resync_q    <= 1'b0;
          sync_adjustment_q <= 4'd0;
          sync_direction_q  <= 1'b0;
        end else begin
          case (state_q)
            ST_ARMED: begin
              if (!hard_sync_enable) begin
                state_q <= ST_TRACK;
                if (edge_det) begin
                  sync_ignored_q <= 1'b1;
                end
              end
            end
            ST_TRACK: begin
              if (edge_det) begin
                if (sync_lock_q || !sampled_bit_q) begin
                  sync_ignored_q <= 1'b1;
                end else begin
                  sync_lock_q <= 1'b1;
                  case (current_segment)
                    SYNC_SEG: begin
                      state_q <= ST_TRACK;
                    end
                    PROP_SEG: begin
                      adj_q   <= adj_fwd;
                      dir_q   <= 1'b0;
                      state_q <= ST_PENDING;
                    end
                    PHASE_SEG1: begin
                      if (quanta_counter < ph1_last) begin
                        adj_q             <= adj_fwd;
                        dir_q             <= 1'b0;
                        state_q           <= ST_ACTIVE;
                        apply_resync_q    <= 1'b1;
                        sync_adjustment_q <= adj_fwd;
                        sync_direction_q  <= 1'b0;
                      end else begin
                        sync_ignored_q <= 1'b1;
                      end
                    end
                    default: begin
                      if (lim <= 6'sd0) begin
                        sync_ignored_q <= 1'b1;
                      end else begin
                        adj_q             <= adj_bwd;
                        dir_q             <= 1'b1;
                        state_q           <= ST_ACTIVE;
                        apply_resync_q    <= 1'b1;
                        sync_adjustment_q <= adj_bwd;
                        sync_direction_q  <= 1'b1;
                      end
                    end
                  endcase
                end
              end else if (hard_sync_enable && !hse_q) begin
                state_q <= ST_ARMED;
              end
            end
            ST_PENDING: begin
              if (edge_det) begin
                sync_ignored_q <= 1'b1;
              end
              if (current_segment == PHASE_SEG1) begin
                state_q           <= ST_ACTIVE;
                apply_resync_q    <= 1'b1;
                sync_adjustment_q <= adj_q;
                sync_direction_q  <= dir_q;
              end
            end
            default: begin
              if (edge_det) begin
                sync_ignored_q <= 1'b1;
              end
              if (bit_timing_end) begin
                state_q           <= ST_TRACK;
                apply_resync_q    <= 1'b0;
                sync_adjustment_q <= 4'd0;
                sync_direction_q  <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

  assign apply_hard_sync = apply_hard_sync_q;
  assign apply_resync    = apply_resync_q;
  assign sync_adjustment = sync_adjustment_q;
  assign sync_direction  = sync_direction_q;
  assign sampled_bit     = sampled_bit_q;
  assign edge_pulse      = edge_pulse_q;
  assign sync_ignored    = sync_ignored_q;

endmodule

// File: tb/tb_can_sync_controller.sv
// tb/tb_can_sync_controller.sv - self-checking bench for can_sync_controller
module tb_can_sync_controller;
  import can_timing_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       tq_pulse;
  logic       rx;
  logic       hard_sync_enable;
  logic [3:0] sjw;
  logic [3:0] phase_seg1;
  logic [3:0] phase_seg2;
  logic [1:0] current_segment;
  logic [4:0] quanta_counter;
  logic [4:0] bit_quanta_counter;
  logic       sample_point;
  logic       bit_timing_end;
  logic       apply_hard_sync;
  logic       apply_resync;
  logic [3:0] sync_adjustment;
  logic       sync_direction;
  logic       sampled_bit;
  logic       edge_pulse;
  logic       sync_ignored;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       hse;
    logic       sb;
    logic [3:0] sjw;
    logic [1:0] seg;
    logic [4:0] qc;
    logic [4:0] bqc;
    logic       hard;
    logic       res;
    logic [3:0] adj;
    logic       dir;
    logic       ign;
    string      name;
  } vec_t;

  vec_t vecs[12];
  vec_t exp_q[$];

  can_sync_controller #(.SYNC_STAGES(2)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .enable            (enable),
    .tq_pulse          (tq_pulse),
    .rx                (rx),
    .hard_sync_enable  (hard_sync_enable),
    .sjw               (sjw),
    .phase_seg1        (phase_seg1),
    .phase_seg2        (phase_seg2),
    .current_segment   (current_segment),
    .quanta_counter    (quanta_counter),
    .bit_quanta_counter(bit_quanta_counter),
    .sample_point      (sample_point),
    .bit_timing_end    (bit_timing_end),
    .apply_hard_sync   (apply_hard_sync),
    .apply_resync      (apply_resync),
    .sync_adjustment   (sync_adjustment),
    .sync_direction    (sync_direction),
    .sampled_bit       (sampled_bit),
    .edge_pulse        (edge_pulse),
    .sync_ignored      (sync_ignored)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(logic hse, logic sb, logic [3:0] s, logic [1:0] seg,
                              logic [4:0] qc, logic [4:0] bqc, logic hard, logic res,
                              logic [3:0] adj, logic dir, logic ign, string name);
    vec_t v;
    v.hse = hse; v.sb = sb; v.sjw = s; v.seg = seg; v.qc = qc; v.bqc = bqc;
    v.hard = hard; v.res = res; v.adj = adj; v.dir = dir; v.ign = ign; v.name = name;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic end_bit();
    bit_timing_end = 1'b1;
    tick();
    bit_timing_end = 1'b0;
  endtask

  task automatic set_sampled(logic b);
    rx = b;
    repeat (3) tick();
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    rx = 1'b1;
    repeat (3) tick();
    tq_pulse = 1'b1;
    tick();
    tq_pulse = 1'b0;
    tick();
  endtask

  task automatic restore_rx();
    rx = 1'b1;
    repeat (3) tick();
    tq_pulse = 1'b1;
    tick();
    tq_pulse = 1'b0;
    tick();
  endtask

  task automatic make_edge(logic [1:0] seg, logic [4:0] qc, logic [4:0] bqc);
    bit seen;
    current_segment    = seg;
    quanta_counter     = qc;
    bit_quanta_counter = bqc;
    rx = 1'b0;
    repeat (3) tick();
    tq_pulse = 1'b1;
    tick();
    tq_pulse = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (edge_pulse) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("edge_pulse_seen", int'(seen), 1);
  endtask

  task automatic run_vector(vec_t v);
    vec_t e;
    hard_sync_enable = 1'b0;
    tick();
    end_bit();
    set_sampled(v.sb);
    sjw = v.sjw;
    hard_sync_enable = v.hse;
    tick();
    exp_q.push_back(v);
    make_edge(v.seg, v.qc, v.bqc);
    e = exp_q.pop_front();
    chk({e.name, "_hard"}, int'(apply_hard_sync), int'(e.hard));
    chk({e.name, "_ign"}, int'(sync_ignored), int'(e.ign));
    chk({e.name, "_res_at_edge"}, int'(apply_resync), int'(e.res && (e.seg != PROP_SEG)));
    current_segment = PHASE_SEG1;
    rx = 1'b1;
    tick();
    chk({e.name, "_pulses_off"}, int'({apply_hard_sync, sync_ignored, edge_pulse}), 0);
    chk({e.name, "_res"}, int'(apply_resync), int'(e.res));
    chk({e.name, "_adj"}, int'(sync_adjustment), e.res ? int'(e.adj) : 0);
    chk({e.name, "_dir"}, int'(sync_direction), e.res ? int'(e.dir) : 0);
    tick();
    chk({e.name, "_res_held"}, int'(apply_resync), int'(e.res));
    end_bit();
    chk({e.name, "_res_cleared"}, int'({apply_resync, sync_adjustment, sync_direction}), 0);
    restore_rx();
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 2, PROP_SEG,   0, 1, 1, 0, 0, 0, 0, "hs_prop");
    vecs[1]  = mk(1, 0, 2, SYNC_SEG,   0, 0, 1, 0, 0, 0, 0, "hs_dominant");
    vecs[2]  = mk(0, 1, 2, PROP_SEG,   1, 2, 0, 1, 2, 0, 0, "prop_bq2");
    vecs[3]  = mk(0, 1, 2, PHASE_SEG2, 0, 6, 0, 1, 1, 1, 0, "ph2_q0");
    vecs[4]  = mk(0, 1, 2, PHASE_SEG2, 1, 7, 0, 0, 0, 0, 1, "ph2_q1");
    vecs[5]  = mk(0, 0, 2, PROP_SEG,   1, 2, 0, 0, 0, 0, 1, "dom_sample");
    vecs[6]  = mk(0, 1, 7, PHASE_SEG1, 1, 5, 0, 1, 4, 0, 0, "sjw7");
    vecs[7]  = mk(0, 1, 0, PHASE_SEG1, 1, 5, 0, 1, 1, 0, 0, "sjw0");
    vecs[8]  = mk(0, 1, 2, PHASE_SEG1, 2, 5, 0, 0, 0, 0, 1, "ph1_last");
    vecs[9]  = mk(0, 1, 2, SYNC_SEG,   0, 0, 0, 0, 0, 0, 0, "sync_seg");
    vecs[10] = mk(0, 1, 3, PROP_SEG,   0, 1, 0, 1, 1, 0, 0, "sjw3_prop");
    vecs[11] = mk(0, 1, 3, PHASE_SEG1, 0, 3, 0, 1, 3, 0, 0, "sjw3_ph1");

    reset_n = 1'b0; enable = 1'b1; tq_pulse = 1'b0; rx = 1'b1;
    hard_sync_enable = 1'b0; sjw = 4'd2; phase_seg1 = 4'd3; phase_seg2 = 4'd3;
    current_segment = SYNC_SEG; quanta_counter = 5'd0; bit_quanta_counter = 5'd0;
    sample_point = 1'b0; bit_timing_end = 1'b0;
    repeat (3) tick();
    chk("rst_hard", int'(apply_hard_sync), 0);
    chk("rst_resync", int'(apply_resync), 0);
    chk("rst_adj", int'(sync_adjustment), 0);
    chk("rst_dir", int'(sync_direction), 0);
    chk("rst_sampled", int'(sampled_bit), 1);
    chk("rst_edge", int'(edge_pulse), 0);
    chk("rst_ign", int'(sync_ignored), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 12; i++) run_vector(vecs[i]);

    // second edge in the same bit is locked out
    hard_sync_enable = 1'b0; sjw = 4'd2;
    tick(); end_bit(); set_sampled(1'b1);
    make_edge(SYNC_SEG, 0, 0);
    chk("dbl_first_ign", int'(sync_ignored), 0);
    restore_rx();
    make_edge(PROP_SEG, 0, 1);
    chk("dbl_second_ign", int'(sync_ignored), 1);
    current_segment = PHASE_SEG1; rx = 1'b1;
    repeat (2) tick();
    chk("dbl_no_resync", int'(apply_resync), 0);
    end_bit(); restore_rx();

    // hard sync aborts an active resync
    end_bit(); set_sampled(1'b1);
    make_edge(PHASE_SEG2, 0, 4);
    chk("abort_res_on", int'(apply_resync), 1);
    restore_rx();
    chk("abort_res_held", int'(apply_resync), 1);
    hard_sync_enable = 1'b1;
    tick();
    make_edge(PROP_SEG, 0, 1);
    chk("abort_hard", int'(apply_hard_sync), 1);
    chk("abort_res_off", int'({apply_resync, sync_adjustment}), 0);
    tick();
    chk("abort_hard_one_clk", int'(apply_hard_sync), 0);
    restore_rx();
    hard_sync_enable = 1'b0;
    tick();

    // enable low drops an active resync
    end_bit(); set_sampled(1'b1);
    make_edge(PHASE_SEG2, 0, 4);
    chk("en_res_on", int'(apply_resync), 1);
    enable = 1'b0;
    tick();
    chk("en_res_off", int'({apply_resync, sync_adjustment, sync_direction}), 0);
    enable = 1'b1;
    restore_rx();

    // asynchronous reset while a resync is active
    end_bit(); set_sampled(1'b1);
    make_edge(PHASE_SEG2, 0, 4);
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    chk("arst_pre_sampled", int'(sampled_bit), 0);
    chk("arst_pre_res", int'(apply_resync), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_res", int'({apply_resync, sync_adjustment, sync_direction}), 0);
    chk("arst_sampled", int'(sampled_bit), 1);
    chk("arst_pulses", int'({apply_hard_sync, edge_pulse, sync_ignored}), 0);
    rx = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    sjw = 4'd2;
    make_edge(PROP_SEG, 1, 2);
    chk("post_rst_ign", int'(sync_ignored), 0);
    current_segment = PHASE_SEG1; rx = 1'b1;
    tick();
    chk("post_rst_res", int'(apply_resync), 1);
    chk("post_rst_adj", int'(sync_adjustment), 2);
    chk("post_rst_dir", int'(sync_direction), 0);
    end_bit();
    chk("post_rst_cleared", int'(apply_resync), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
